mem_scan_ctrl: RTL and testbench
================================

Name: mem_scan_ctrl

Overview:
- Sequencing initiator for the two-read/one-write operand memory (Mem) and the result memory (Memoria_Res).
- On a start pulse it walks a block of operand pairs: A from DirLec and B from Dir2Lec.
- For each pair it applies one ALU operation and writes the result into the result memory.
- It lets the operand store and result store be exercised as a batch engine without external address sequencing.

Parameters:
- DATA_W, 32, operand/result width.
- ADDR_W, 5, address width of both memories; all address arithmetic wraps modulo 2^ADDR_W.
- LEN_W, 6, width of length input (max 2^ADDR_W elements).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- base_a  input  ADDR_W  first address for operand A.
- base_b  input  ADDR_W  first address for operand B.
- base_r  input  ADDR_W  first result address.
- len  input  LEN_W  element count; 0 is legal.
- op  input  3  000 add, 001 sub (A-B), 010 and, 011 or, 100 xor, 101 signed slt (1/0), 110 pass A, 111 pass B.
- dir_lec  output  ADDR_W  operand A read address to Mem.
- dir2_lec  output  ADDR_W  operand B read address to Mem.
- mem_we  output  1  operand-memory write enable; tied 0 (reads only).
- dato1  input  DATA_W  operand A from Mem, combinational.
- dato2  input  DATA_W  operand B from Mem, combinational.
- res_dir  output  ADDR_W  result memory address.
- res_dato  output  DATA_W  result write data.
- res_we  output  1  result write enable, one-cycle pulse per element.
- busy  output  1  high from the cycle after start acceptance until DONE exits.
- done  output  1  one-cycle pulse at end of batch.

Behaviour:
- Reset (async, any state): state=IDLE; index, dir_lec, dir2_lec, res_dir, res_dato, res_we, busy, done, mem_we all 0.
- Reset mid-batch: the batch is abandoned with no further writes.
- On start in IDLE: register base_a, base_b, base_r, len, op; clear index i.
  - len==0 -> DONE.
  - Otherwise -> READ.
  - Inputs changing after acceptance have no effect.
- READ (1 cycle): dir_lec=base_a+i, dir2_lec=base_b+i. At cycle end, capture dato1/dato2 into opa/opb. Go to EXEC.
- EXEC (1 cycle): res_q = f(op, opa, opb), truncated to DATA_W. Go to WRITE.
  - add/sub wrap; no carry output.
  - slt compares as two's complement; result is zero-extended 1/0.
- WRITE (1 cycle): res_we=1, res_dir=base_r+i, res_dato=res_q.
  - If i==len-1 -> DONE; else i<=i+1 -> READ.
- DONE (1 cycle): done=1, busy=0 -> IDLE.
- Throughput: 3 cycles per element. Latency from start to done = 3*len+2 cycles; len=0 gives done 2 cycles after start.
- start outside IDLE is ignored (no queuing). start in the DONE cycle is also ignored.
- Address wrap: base+i beyond 2^ADDR_W-1 wraps to 0. Overlapping A/B/R windows are legal. The result memory is separate, so there is no read-after-write hazard.
- res_dato and res_dir hold their last values outside WRITE. res_we is 0 outside WRITE.

Optional Feature:
- Macro: MEM_SCAN_ZCOUNT_EN.
- With the macro defined:
  - Adds output zero_cnt [LEN_W-1:0], counting WRITE cycles whose res_dato==0 in the current batch.
  - zero_cnt clears on start acceptance and on reset.
  - zero_cnt is stable and valid from the done pulse until the next accepted start.
- Without the macro: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset mid-batch: assert rst during EXEC of element 2 -> all outputs 0 immediately, no further res_we; a new start works normally.
- Add batch: mem A[0..3]={1,2,3,4}, B at base_b=8 ={10,20,30,40}, base_r=0, len=4, op=000 -> res_we pulses at cycles 4,7,10,13 after start, writing {11,22,33,44} to 0..3; done at cycle 14.
- Sub and signed slt on one pair: A=0x00000005, B=0xFFFFFFFF, len=1 -> op=001 writes 0x00000006; op=101 writes 0 (5 < -1 is false).
- Wrap-around: base_a=30, base_b=0, base_r=31, len=3, op=110 -> reads A at 30,31,0; writes to 31,0,1.
- Zero length plus ignored start: len=0 -> done 2 cycles after start with no res_we; a second start pulsed while busy in a len=4 batch is ignored (exactly 4 writes).
- MEM_SCAN_ZCOUNT_EN: op=100 with A==B for 3 of 5 elements -> zero_cnt=3 at done.

Source files
------------

// File: rtl/mem_scan_ctrl.sv
// Batch sequencer: reads operand pairs from Mem, applies one ALU op, writes results to Memoria_Res.
// Optional per-batch zero-result counter enabled by defining MEM_SCAN_ZCOUNT_EN.
module mem_scan_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LEN_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_r,
    input  logic [LEN_W-1:0]  len,
    input  logic [2:0]        op,
    output logic [ADDR_W-1:0] dir_lec,
    output logic [ADDR_W-1:0] dir2_lec,
    output logic              mem_we,
    input  logic [DATA_W-1:0] dato1,
    input  logic [DATA_W-1:0] dato2,
    output logic [ADDR_W-1:0] res_dir,
    output logic [DATA_W-1:0] res_dato,
    output logic              res_we,
    output logic              busy,
    output logic              done
`ifdef MEM_SCAN_ZCOUNT_EN
    ,
    output logic [LEN_W-1:0]  zero_cnt
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WRITE, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_base_a, r_base_b, r_base_r;
    logic [LEN_W-1:0]    r_len, r_idx;
    logic [2:0]          r_op;
    logic [DATA_W-1:0]   r_opa, r_opb, r_res_q;
    logic [ADDR_W-1:0]   r_dir_lec, r_dir2_lec, r_res_dir;
    logic [DATA_W-1:0]   r_res_dato;
    logic                r_res_we, r_busy, r_done;

    logic [LEN_W-1:0]    w_idx_inc;
    logic                w_last, w_accept, w_advance, w_res_we_d, w_done_d;
    logic [DATA_W-1:0]   w_alu;

    assign w_idx_inc = r_idx + LEN_W'(1);
    assign w_last    = (r_idx == (r_len - LEN_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = (len == '0) ? S_DONE : S_READ;
            S_READ:  w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = w_last ? S_DONE : S_READ;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept   = (r_state == S_IDLE) && start;
        w_advance  = (r_state == S_WRITE) && !w_last;
        w_res_we_d = (r_state == S_WRITE);
        w_done_d   = (r_state == S_DONE);
        w_alu      = '0;
        case (r_op)
            3'b000: w_alu = r_opa + r_opb;
            3'b001: w_alu = r_opa - r_opb;
            3'b010: w_alu = r_opa & r_opb;
            3'b011: w_alu = r_opa | r_opb;
            3'b100: w_alu = r_opa ^ r_opb;
            3'b101: w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_opa) < $signed(r_opb))};
            3'b110: w_alu = r_opa;
            3'b111: w_alu = r_opb;
            default: w_alu = '0;
        endcase
    end

    // Write-side outputs are registered from the state, so they trail WRITE/DONE by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base_a   <= '0;
            r_base_b   <= '0;
            r_base_r   <= '0;
            r_len      <= '0;
            r_op       <= '0;
            r_idx      <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_res_q    <= '0;
            r_dir_lec  <= '0;
            r_dir2_lec <= '0;
            r_res_dir  <= '0;
            r_res_dato <= '0;
            r_res_we   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_base_a   <= base_a;
                r_base_b   <= base_b;
                r_base_r   <= base_r;
                r_len      <= len;
                r_op       <= op;
                r_idx      <= '0;
                r_dir_lec  <= base_a;
                r_dir2_lec <= base_b;
                r_busy     <= 1'b1;
            end
            if (w_advance) begin
                r_idx      <= w_idx_inc;
                r_dir_lec  <= r_base_a + w_idx_inc[ADDR_W-1:0];
                r_dir2_lec <= r_base_b + w_idx_inc[ADDR_W-1:0];
            end
            if (r_state == S_READ) begin
                r_opa <= dato1;
                r_opb <= dato2;
            end
            if (r_state == S_EXEC) r_res_q <= w_alu;
            r_res_we <= w_res_we_d;
            if (w_res_we_d) begin
                r_res_dir  <= r_base_r + r_idx[ADDR_W-1:0];
                r_res_dato <= r_res_q;
            end
            r_done <= w_done_d;
            if (w_done_d) r_busy <= 1'b0;
        end
    end

`ifdef MEM_SCAN_ZCOUNT_EN
    logic [LEN_W-1:0] r_zero_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               r_zero_cnt <= '0;
        else if (w_accept)                     r_zero_cnt <= '0;
        else if (w_res_we_d && r_res_q == '0)  r_zero_cnt <= r_zero_cnt + LEN_W'(1);
    end

    assign zero_cnt = r_zero_cnt;
`endif

    assign dir_lec  = r_dir_lec;
    assign dir2_lec = r_dir2_lec;
    assign mem_we   = 1'b0;
    assign res_dir  = r_res_dir;
    assign res_dato = r_res_dato;
    assign res_we   = r_res_we;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Directed scoreboard bench for mem_scan_ctrl: expected writes are queued at start, popped on res_we.
module tb_mem_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start = 1'b0;
    logic [4:0]  base_a = '0, base_b = '0, base_r = '0;
    logic [5:0]  len = '0;
    logic [2:0]  op = '0;
    logic [4:0]  dir_lec, dir2_lec, res_dir;
    logic        mem_we, res_we, busy, done;
    logic [31:0] dato1, dato2, res_dato;
`ifdef MEM_SCAN_ZCOUNT_EN
    logic [5:0]  zero_cnt;
`endif

    logic [31:0] mem [32];
    assign dato1 = mem[dir_lec];
    assign dato2 = mem[dir2_lec];

    mem_scan_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .base_a(base_a), .base_b(base_b), .base_r(base_r),
        .len(len), .op(op),
        .dir_lec(dir_lec), .dir2_lec(dir2_lec), .mem_we(mem_we),
        .dato1(dato1), .dato2(dato2),
        .res_dir(res_dir), .res_dato(res_dato), .res_we(res_we),
        .busy(busy), .done(done)
`ifdef MEM_SCAN_ZCOUNT_EN
        , .zero_cnt(zero_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks = 0, errors = 0;
    int unexp_writes = 0, done_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return a;
            default: return b;
        endcase
    endfunction

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (res_we) begin
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("wr_addr", 64'(res_dir), 64'(mon_e.addr));
                chk("wr_data", 64'(res_dato), 64'(mon_e.data));
                chk("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
            end else begin
                unexp_writes++;
            end
        end
    end

    // extra: cycle offset after start at which a second (ignored) start is pulsed; -1 for none
    task automatic run_batch(input string tag, input logic [4:0] ba, input logic [4:0] bb,
                             input logic [4:0] br, input logic [5:0] n, input logic [2:0] o,
                             input int extra);
        int s, dcyc, zexp, dc0;
        bit seen;
        logic [31:0] r;
        @(posedge clk); #1;
        s = cyc; zexp = 0; seen = 0; dcyc = 0; dc0 = done_cnt;
        for (int k = 0; k < int'(n); k++) begin
            r = alu(o, mem[5'(int'(ba) + k)], mem[5'(int'(bb) + k)]);
            if (r == 32'd0) zexp++;
            sb.push_back('{addr: 5'(int'(br) + k), data: r, cyc: s + 4 + 3 * k});
        end
        base_a = ba; base_b = bb; base_r = br; len = n; op = o; start = 1'b1;
        for (int k = 1; k < 200; k++) begin
            @(posedge clk); #1;
            start  = (k == extra);
            base_a = 5'($urandom); base_b = 5'($urandom); base_r = 5'($urandom);
            len    = 6'($urandom_range(1, 32)); op = 3'($urandom);
            if (k == 1) chk({tag, "_busy_after_accept"}, 64'(busy), 64'd1);
            @(negedge clk);
            if (done) begin
                seen = 1'b1; dcyc = cyc;
                break;
            end
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_done_cycle"}, 64'(dcyc), 64'(s + 3 * int'(n) + 2));
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
`ifdef MEM_SCAN_ZCOUNT_EN
        chk({tag, "_zero_cnt"}, 64'(zero_cnt), 64'(zexp));
`endif
        @(posedge clk); #1; start = 1'b0;
        repeat (6) @(negedge clk);
        chk({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
        chk({tag, "_no_extra_writes"}, 64'(unexp_writes), 64'd0);
        chk({tag, "_single_done"}, 64'(done_cnt), 64'(dc0 + 1));
        sb.delete();
    endtask

    initial begin
        int s;
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000 + 32'(i) * 32'h11;
        rst = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("rst_res_we", 64'(res_we), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dir_lec", 64'(dir_lec), 64'd0);
        chk("rst_res_dato", 64'(res_dato), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        rst = 1'b0;

        // Reset mid-batch: assert rst while element 2 is in EXEC.
        @(posedge clk); #1;
        s = cyc;
        for (int k = 0; k < 4; k++)
            sb.push_back('{addr: 5'(k), data: mem[k] + mem[8 + k], cyc: s + 4 + 3 * k});
        base_a = 5'd0; base_b = 5'd8; base_r = 5'd0; len = 6'd4; op = 3'd0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        while (cyc < s + 8) begin @(posedge clk); #1; end
        chk("midrst_writes_before", 64'(sb.size()), 64'd2);
        rst = 1'b1;
        #1;
        chk("midrst_res_we", 64'(res_we), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_res_dato", 64'(res_dato), 64'd0);
        chk("midrst_res_dir", 64'(res_dir), 64'd0);
        chk("midrst_dir_lec", 64'(dir_lec), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("midrst_no_writes", 64'(unexp_writes), 64'd0);
        chk("midrst_no_done", 64'(done_cnt), 64'd0);

        // Add batch
        for (int i = 0; i < 4; i++) begin
            mem[i]     = 32'(i + 1);
            mem[8 + i] = 32'(10 * (i + 1));
        end
        run_batch("add", 5'd0, 5'd8, 5'd0, 6'd4, 3'd0, -1);

        // Sub and signed slt on one pair
        mem[12] = 32'h0000_0005; mem[13] = 32'hFFFF_FFFF;
        run_batch("sub", 5'd12, 5'd13, 5'd5, 6'd1, 3'd1, -1);
        run_batch("slt_false", 5'd12, 5'd13, 5'd6, 6'd1, 3'd5, -1);
        run_batch("slt_true", 5'd13, 5'd12, 5'd7, 6'd1, 3'd5, -1);

        // Wrap-around
        mem[30] = 32'hAAAA_0030; mem[31] = 32'hAAAA_0031; mem[0] = 32'hAAAA_0000;
        run_batch("wrap", 5'd30, 5'd0, 5'd31, 6'd3, 3'd6, -1);

        // Zero length, ignored start while busy, ignored start in DONE
        run_batch("len0", 5'd3, 5'd4, 5'd5, 6'd0, 3'd0, -1);
        run_batch("busy_start", 5'd0, 5'd8, 5'd16, 6'd4, 3'd0, 5);
        run_batch("done_start", 5'd2, 5'd9, 5'd20, 6'd2, 3'd1, 3 * 2 + 1);

        // Remaining ops on random data
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        run_batch("and", 5'd4, 5'd20, 5'd1, 6'd2, 3'd2, -1);
        run_batch("or", 5'd6, 5'd22, 5'd3, 6'd2, 3'd3, -1);
        run_batch("xor", 5'd8, 5'd24, 5'd5, 6'd2, 3'd4, -1);
        run_batch("passb", 5'd10, 5'd26, 5'd7, 6'd2, 3'd7, -1);
        run_batch("add_rand", 5'd12, 5'd28, 5'd9, 6'd3, 3'd0, -1);

        // xor with A==B on three of five elements
        for (int i = 0; i < 5; i++) mem[16 + i] = 32'h5A5A_0000 + 32'(i);
        mem[21] = mem[16]; mem[22] = 32'h1234_5678; mem[23] = mem[18];
        mem[24] = 32'h0F0F_0F0F; mem[25] = mem[20];
        run_batch("zcount", 5'd16, 5'd21, 5'd10, 6'd5, 3'd4, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
